// File: rtl/dram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : dram_frame_reader
// Purpose  : Reads one frame back from DRAM in fixed-length bursts, buffers
//            the returned words in a credit-checked FIFO, and narrows each
//            DRAM word into an AXI4-Stream pixel stream with SOF (tuser) and
//            end-of-line (tlast) markers.
// Ports    : m_axi_aclk / m_axi_aresetn  clock, asynchronous active-low reset
//            start, busy, frame_done      frame control / status
//            dram_read_*                  DRAM controller read interface
//            m_axis_*                     pixel stream output
// Options  : FRAME_READER_LOOP_EN - when defined, the reader restarts at the
//            frame base after every frame instead of returning to idle.
// Revision : 1.0 - initial release
// ============================================================================
module dram_frame_reader #(
  parameter int                         DRAM_ADDR_WIDTH = 39,
  parameter int                         DRAM_DATA_WIDTH = 512,
  parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE  = DRAM_ADDR_WIDTH'(32'h8000_0000),
  parameter int                         OUT_DATA_WIDTH  = 64,
  parameter int                         BURST_LEN       = 16,
  parameter int                         LINE_WORDS      = 64,
  parameter int                         FRAME_WORDS     = 4096,
  parameter int                         FIFO_DEPTH      = 64
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_aresetn,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  output logic                       dram_read_en,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  input  logic                       dram_read_data_valid,
  input  logic                       dram_read_busy,
  output logic [OUT_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser
);

  localparam int c_RATIO      = DRAM_DATA_WIDTH / OUT_DATA_WIDTH;
  localparam int c_NUM_BURSTS = FRAME_WORDS / BURST_LEN;
  localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int c_RES_W      = c_CNT_W + 1;
  localparam int c_SL_W       = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
  localparam int c_LW_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int c_FW_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int c_NB_W       = (c_NUM_BURSTS > 1) ? $clog2(c_NUM_BURSTS) : 1;

  localparam logic [DRAM_ADDR_WIDTH-1:0] c_ADDR_STEP =
    DRAM_ADDR_WIDTH'(BURST_LEN * (DRAM_DATA_WIDTH / 8));
  localparam logic [c_CNT_W-1:0] c_BURST          = c_CNT_W'(BURST_LEN);
  // Issue allowed while reserved <= FIFO_DEPTH - BURST_LEN (free space >= one burst).
  localparam logic [c_RES_W-1:0] c_CREDIT_LIMIT   = c_RES_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [c_SL_W-1:0]  c_LAST_SLICE     = c_SL_W'(c_RATIO - 1);
  localparam logic [c_LW_W-1:0]  c_LAST_LINE_WORD = c_LW_W'(LINE_WORDS - 1);
  localparam logic [c_FW_W-1:0]  c_LAST_WORD      = c_FW_W'(FRAME_WORDS - 1);
  localparam logic [c_NB_W-1:0]  c_LAST_BURST     = c_NB_W'(c_NUM_BURSTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [c_NB_W-1:0]          bursts_q, bursts_d;
  logic [c_FW_W-1:0]          word_idx_q, word_idx_d;
  logic [c_LW_W-1:0]          line_idx_q, line_idx_d;
  logic [c_SL_W-1:0]          slice_q, slice_d;
  logic [c_PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]         count_q, count_d;
  logic [c_CNT_W-1:0]         outstanding_q, outstanding_d;
  logic                       en_prev_q;

  logic [DRAM_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                       w_issue;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_accept;
  logic                       w_tvalid;
  logic                       w_last_slice;
  logic [c_RES_W-1:0]         w_reserved;
  logic [DRAM_DATA_WIDTH-1:0] w_head;

  // --------------------------------------------------------------------------
  // Request credit and FIFO handshakes
  // --------------------------------------------------------------------------
  assign w_reserved   = c_RES_W'(count_q) + c_RES_W'(outstanding_q);
  assign w_issue      = (state_q == S_REQ) && (w_reserved <= c_CREDIT_LIMIT) &&
                        !dram_read_busy && !en_prev_q;
  // Only beats that belong to an issued burst are accepted; stray beats while
  // idle (e.g. left over from an aborted frame) are dropped.
  assign w_push       = dram_read_data_valid && (state_q != S_IDLE) &&
                        (outstanding_q != '0);
  assign w_tvalid     = (count_q != '0);
  assign w_last_slice = (slice_q == c_LAST_SLICE);
  assign w_accept     = w_tvalid && m_axis_tready;
  assign w_pop        = w_accept && w_last_slice;

  // --------------------------------------------------------------------------
  // Output stream: slice k of the head word, LSBs first
  // --------------------------------------------------------------------------
  assign w_head         = mem_q[rd_ptr_q];
  assign m_axis_tvalid  = w_tvalid;
  assign m_axis_tdata   = w_tvalid ? w_head[int'(slice_q)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]
                                   : '0;
  assign m_axis_tuser   = w_tvalid && (word_idx_q == '0) && (slice_q == '0);
  assign m_axis_tlast   = w_tvalid && w_last_slice && (line_idx_q == c_LAST_LINE_WORD);

  assign dram_read_addr = addr_q;
  assign dram_read_len  = 8'(BURST_LEN - 1);
  assign dram_read_en   = w_issue;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state, frame counters and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bursts_d   = bursts_q;
    word_idx_d = word_idx_q;
    line_idx_d = line_idx_q;
    busy       = (state_q != S_IDLE);
    frame_done = 1'b0;

    if (w_pop) begin
      word_idx_d = word_idx_q + c_FW_W'(1);
      line_idx_d = (line_idx_q == c_LAST_LINE_WORD) ? '0 : line_idx_q + c_LW_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_REQ;
          addr_d     = DRAM_ADDR_BASE;
          bursts_d   = '0;
          word_idx_d = '0;
          line_idx_d = '0;
        end
      end
      S_REQ: begin
        if (w_issue) begin
          addr_d   = addr_q + c_ADDR_STEP;
          bursts_d = bursts_q + c_NB_W'(1);
          if (bursts_q == c_LAST_BURST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Popping the last word of the frame implies nothing is outstanding
        // and the FIFO is empty after this pop.
        if (w_pop && (word_idx_q == c_LAST_WORD)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
`ifdef FRAME_READER_LOOP_EN
        state_d    = S_REQ;
        addr_d     = DRAM_ADDR_BASE;
        bursts_d   = '0;
        word_idx_d = '0;
        line_idx_d = '0;
`else
        state_d    = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO pointers, occupancy, outstanding beats and slice position
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d      = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    slice_d       = slice_q;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (w_issue) begin
      outstanding_d = outstanding_d + c_BURST;
    end
    if (w_push) begin
      outstanding_d = outstanding_d - c_CNT_W'(1);
    end

    if (w_accept) begin
      slice_d = w_last_slice ? '0 : slice_q + c_SL_W'(1);
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      addr_q        <= DRAM_ADDR_BASE;
      bursts_q      <= '0;
      word_idx_q    <= '0;
      line_idx_q    <= '0;
      slice_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      en_prev_q     <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      bursts_q      <= bursts_d;
      word_idx_q    <= word_idx_d;
      line_idx_q    <= line_idx_d;
      slice_q       <= slice_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      en_prev_q     <= w_issue;
    end
  end

  // Word storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge m_axi_aclk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= dram_read_data;
    end
  end

endmodule
`default_nettype wire
